// File: rtl/line_tile_mux_pkg.sv
// Shared video definitions for the line tiling multiplexer: FSM encoding and
// channel-index width helpers.
package line_tile_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_SEND      = 2'd2
    } lt_state_e;

    localparam int NUM_CH_DEF = 2;

    // Index width for n items, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_width(NUM_CH_DEF);

endpackage

// File: rtl/line_tile_mux_fifo.sv
// Synchronous first-word-fall-through FIFO: dout always shows the head word,
// flush empties it and a write in the flush cycle lands as the first word.
module sync_fwft_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_wr_s;
    logic              do_rd_s;
    logic              mem_we_s;
    logic [AW-1:0]     mem_wa_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Accept a write into a full FIFO only when the head leaves in the same cycle.
    always_comb begin
        do_rd_s  = rd_en & ~empty & ~flush;
        do_wr_s  = wr_en & (flush | ~full | do_rd_s);
        mem_we_s = do_wr_s & ~rst;
        if (flush) begin
            mem_wa_s = {AW{1'b0}};
        end else begin
            mem_wa_s = wr_ptr_r;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= wr_en ? AW'(1) : {AW{1'b0}};
            count_r  <= wr_en ? CNT_W'(1) : {CNT_W{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= din;
        end
    end

endmodule

// File: rtl/line_tile_mux.sv
// Buffers NUM_CH camera pixel streams and emits composite lines, either all
// channels side by side or one selected channel, on a ready/valid output.
module line_tile_mux
    import line_tile_mux_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 16,
    parameter int H_CH       = 512,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_vsync,
    input  logic [NUM_CH-1:0]          in_de,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic                       mode,
    input  logic [$clog2(NUM_CH)-1:0]  sel,
    input  logic                       out_ready,
    output logic                       out_vsync,
    output logic                       out_de,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_eol,
    output logic [NUM_CH-1:0]          ovf
);

    localparam int CH_IDX_W = ch_width(NUM_CH);
    localparam int PIX_W    = ch_width(H_CH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PIX_W-1:0]    PIX_LAST   = PIX_W'(H_CH - 1);
    localparam logic [CH_IDX_W-1:0] CH_LAST    = CH_IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]    LINE_WORDS = CNT_W'(H_CH);

    lt_state_e            state_r;
    logic                 vs0_d_r;
    logic                 mode_r;
    logic [CH_IDX_W-1:0]  sel_r;
    logic [CH_IDX_W-1:0]  ch_idx_r;
    logic [PIX_W-1:0]     pix_cnt_r;
    logic                 out_vsync_r;
    logic                 out_de_r;
    logic [NUM_CH-1:0]    ovf_r;

    logic                 frame_start_s;
    logic                 xfer_s;
    logic                 line_end_s;
    logic                 line_ready_s;
    logic [NUM_CH-1:0]    rd_en_s;
    logic [NUM_CH-1:0]    ovf_set_s;
    logic [NUM_CH-1:0]    full_s;
    logic [NUM_CH-1:0]    empty_s;
    logic [DATA_W-1:0]    head_sel_s;
    logic [DATA_W-1:0]    head_s  [NUM_CH];
    logic [CNT_W-1:0]     count_s [NUM_CH];
    logic                 unused_vsync_s;

    // Only channel 0's vsync defines frame timing.
    assign unused_vsync_s = ^in_vsync;

    assign frame_start_s = in_vsync[0] & ~vs0_d_r;
    assign xfer_s        = out_de_r & out_ready;
    assign line_end_s    = (pix_cnt_r == PIX_LAST) & (mode_r | (ch_idx_r == CH_LAST));

    assign out_vsync = out_vsync_r;
    assign out_de    = out_de_r;
    assign out_data  = out_de_r ? head_sel_s : {DATA_W{1'b0}};
    assign out_eol   = out_de_r & line_end_s;
    assign ovf       = ovf_r;

    // Head-word select, read strobes, overflow detection and line-ready check.
    always_comb begin
        rd_en_s      = {NUM_CH{1'b0}};
        ovf_set_s    = {NUM_CH{1'b0}};
        head_sel_s   = {DATA_W{1'b0}};
        line_ready_s = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx_r == CH_IDX_W'(k)) begin
                head_sel_s = head_s[k];
                rd_en_s[k] = xfer_s & ~empty_s[k] & ~frame_start_s;
            end else begin
                rd_en_s[k] = 1'b0;
            end
            ovf_set_s[k] = in_de[k] & full_s[k] & ~rd_en_s[k];
            if ((!mode_r || (sel_r == CH_IDX_W'(k))) && (count_s[k] < LINE_WORDS)) begin
                line_ready_s = 1'b0;
            end else begin
                line_ready_s = line_ready_s;
            end
        end
    end

    // Frame/line sequencing FSM with registered output controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            vs0_d_r     <= 1'b0;
            mode_r      <= 1'b0;
            sel_r       <= {CH_IDX_W{1'b0}};
            ch_idx_r    <= {CH_IDX_W{1'b0}};
            pix_cnt_r   <= {PIX_W{1'b0}};
            out_vsync_r <= 1'b0;
            out_de_r    <= 1'b0;
            ovf_r       <= {NUM_CH{1'b0}};
        end else begin
            vs0_d_r     <= in_vsync[0];
            out_vsync_r <= frame_start_s;
            if (frame_start_s) begin
                // A frame start always wins: flush happens in the FIFOs, any line in flight is dropped.
                mode_r    <= mode;
                sel_r     <= CH_IDX_W'(sel);
                ovf_r     <= {NUM_CH{1'b0}};
                state_r   <= ST_WAIT_LINE;
                out_de_r  <= 1'b0;
                pix_cnt_r <= {PIX_W{1'b0}};
                ch_idx_r  <= {CH_IDX_W{1'b0}};
            end else begin
                ovf_r <= ovf_r | ovf_set_s;
                case (state_r)
                    ST_IDLE: begin
                        out_de_r <= 1'b0;
                    end
                    ST_WAIT_LINE: begin
                        if (line_ready_s) begin
                            state_r   <= ST_SEND;
                            out_de_r  <= 1'b1;
                            pix_cnt_r <= {PIX_W{1'b0}};
                            ch_idx_r  <= mode_r ? sel_r : {CH_IDX_W{1'b0}};
                        end
                    end
                    ST_SEND: begin
                        if (xfer_s) begin
                            if (pix_cnt_r == PIX_LAST) begin
                                pix_cnt_r <= {PIX_W{1'b0}};
                                if (line_end_s) begin
                                    state_r  <= ST_WAIT_LINE;
                                    out_de_r <= 1'b0;
                                    ch_idx_r <= {CH_IDX_W{1'b0}};
                                end else begin
                                    ch_idx_r <= ch_idx_r + CH_IDX_W'(1);
                                end
                            end else begin
                                pix_cnt_r <= pix_cnt_r + PIX_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        out_de_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        sync_fwft_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (frame_start_s),
            .wr_en (in_de[k]),
            .din   (in_data[k*DATA_W +: DATA_W]),
            .rd_en (rd_en_s[k]),
            .dout  (head_s[k]),
            .full  (full_s[k]),
            .empty (empty_s[k]),
            .count (count_s[k])
        );
    end

endmodule

// File: tb/tb_line_tile_mux.sv
// Scoreboard bench for line_tile_mux: expected words are queued as lines are
// written and compared as the DUT presents and transfers them.
module tb_line_tile_mux;
    import line_tile_mux_pkg::*;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 16;
    localparam int H_CH       = 4;
    localparam int FIFO_DEPTH = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        in_vsync;
    logic [NUM_CH-1:0]        in_de;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     mode;
    logic [CH_W-1:0]          sel;
    logic                     out_ready;
    logic                     out_vsync;
    logic                     out_de;
    logic [DATA_W-1:0]        out_data;
    logic                     out_eol;
    logic [NUM_CH-1:0]        ovf;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              eol;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic mon_en  = 1'b0;

    always #5 clk = ~clk;

    line_tile_mux #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .H_CH       (H_CH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vsync  (in_vsync),
        .in_de     (in_de),
        .in_data   (in_data),
        .mode      (mode),
        .sel       (sel),
        .out_ready (out_ready),
        .out_vsync (out_vsync),
        .out_de    (out_de),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .ovf       (ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int d, input logic eol);
        exp_t e;
        e.data = 16'(d);
        e.eol  = eol;
        exp_q.push_back(e);
    endtask

    // Queue a tile line: n words from base0 then n words from base1.
    task automatic expect_tile(input int base0, input int base1);
        for (int i = 0; i < H_CH; i++) expect_word(base0 + i, 1'b0);
        for (int i = 0; i < H_CH; i++) expect_word(base1 + i, (i == H_CH - 1));
    endtask

    task automatic write_lines(input logic [1:0] de, input int b0, input int b1, input int n);
        for (int i = 0; i < n; i++) begin
            in_de   = de;
            in_data = {16'(b1 + i), 16'(b0 + i)};
            tick();
        end
        in_de = 2'b00;
    endtask

    task automatic frame_start();
        in_vsync = 2'b01;
        tick();
        check_val("vsync_pulse", out_vsync, 1);
        in_vsync = 2'b00;
        tick();
        check_val("vsync_single", out_vsync, 0);
    endtask

    task automatic wait_de(input int budget);
        int i = 0;
        while (!out_de && i < budget) begin
            tick();
            i++;
        end
        check_val("de_timeout", out_de, 1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    // Output monitor: head word must match while presented, pop on transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check_val("idle_de", out_de, 0);
            end else if (out_de) begin
                check_val("data", out_data, exp_q[0].data);
                check_val("eol", out_eol, exp_q[0].eol);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_vsync = 2'b00; in_de = 2'b00; in_data = '0;
        mode = 1'b0; sel = '0; out_ready = 1'b1;
        repeat (3) tick();
        check_val("rst_vsync", out_vsync, 0);
        check_val("rst_de", out_de, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_eol", out_eol, 0);
        check_val("rst_ovf", ovf, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Tile mode: 1..4 then 11..14 on consecutive cycles
        frame_start();
        expect_tile(1, 11);
        write_lines(2'b11, 1, 11, H_CH);
        wait_de(20);
        for (int i = 0; i < 2 * H_CH; i++) begin
            @(negedge clk);
            check_val("tile_de_run", out_de, 1);
        end
        @(negedge clk);
        check_val("tile_de_end", out_de, 0);
        tick();
        wait_drain("tile_drain", 20);

        // Single mode on channel 1, mode/sel changes after the frame start are ignored
        mode = 1'b1; sel = 1'b1;
        frame_start();
        mode = 1'b0; sel = 1'b0;
        for (int i = 0; i < H_CH; i++) expect_word(11 + i, (i == H_CH - 1));
        write_lines(2'b11, 1, 11, H_CH);
        wait_drain("single_drain1", 40);
        for (int i = 0; i < H_CH; i++) expect_word(15 + i, (i == H_CH - 1));
        write_lines(2'b11, 5, 15, H_CH);
        wait_drain("single_drain2", 40);
        // ch0 still holds 8 undrained words, so one more must overflow
        write_lines(2'b01, 9, 0, 1);
        check_val("single_ch0_kept", ovf, 2'b01);
        tick();

        // Backpressure with out_ready toggling
        mode = 1'b0;
        frame_start();
        check_val("ovf_clear_fs", ovf, 2'b00);
        expect_tile(41, 51);
        write_lines(2'b11, 41, 51, H_CH);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        wait_drain("bp_drain", 4);
        out_ready = 1'b1;
        tick();

        // Overflow on channel 1 with channel 0 idle
        frame_start();
        write_lines(2'b10, 0, 200, FIFO_DEPTH + 1);
        check_val("ovf_set", ovf, 2'b10);
        frame_start();
        check_val("ovf_cleared", ovf, 2'b00);

        // Abort after two words of a line
        expect_tile(61, 71);
        write_lines(2'b11, 61, 71, H_CH);
        wait_de(20);
        tick();
        tick();
        in_vsync = 2'b01;
        out_ready = 1'b0;
        tick();
        check_val("abort_vsync", out_vsync, 1);
        check_val("abort_de", out_de, 0);
        exp_q.delete();
        in_vsync = 2'b00;
        out_ready = 1'b1;
        tick();
        check_val("abort_vsync_end", out_vsync, 0);
        expect_tile(81, 91);
        write_lines(2'b11, 81, 91, H_CH);
        wait_drain("abort_fresh", 40);

        // Reset in the middle of SEND
        expect_tile(101, 111);
        write_lines(2'b11, 101, 111, H_CH);
        wait_de(20);
        tick();
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        check_val("mrst_de", out_de, 0);
        check_val("mrst_data", out_data, 0);
        check_val("mrst_eol", out_eol, 0);
        check_val("mrst_vsync", out_vsync, 0);
        check_val("mrst_ovf", ovf, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        write_lines(2'b11, 1, 11, H_CH);
        repeat (12) tick();
        check_val("mrst_no_output", out_de, 0);
        frame_start();
        expect_tile(121, 131);
        write_lines(2'b11, 121, 131, H_CH);
        wait_drain("mrst_resume", 40);
        repeat (3) tick();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
